// File: rtl/pipe_sink_pkg.sv
// rtl/pipe_sink_pkg.sv - shared widths, delay-line entry type and expected-result function
package pipe_sink_pkg;

  localparam int CNT_W  = 16;
  localparam int ERR_W  = 8;
  localparam int PIPE_N = 10;

  typedef struct packed {
    logic              vld;
    logic [PIPE_N-1:0] exp;
  } dly_entry_t;

  // Same arithmetic as the upstream pipeline, wrapping at PIPE_N bits.
  function automatic logic [PIPE_N-1:0] pipe_expect(
    input logic [PIPE_N-1:0] a,
    input logic [PIPE_N-1:0] b,
    input logic [PIPE_N-1:0] c,
    input logic [PIPE_N-1:0] d
  );
    logic [PIPE_N-1:0] sum;
    logic [PIPE_N-1:0] prod;
    sum  = (a + b) + (c - d);
    prod = sum * d;
    return prod;
  endfunction

endpackage

// File: rtl/pipe_sink_fifo.sv
// rtl/pipe_sink_fifo.sv - synchronous show-ahead FIFO, power-of-two depth
module pipe_sink_fifo #(
  parameter int N     = 10,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           pop,
  input  logic [N-1:0]   din,
  output logic [N-1:0]   dout,
  output logic [$clog2(DEPTH):0] occ,
  output logic           full,
  output logic           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_occ;
  logic          w_wr;
  logic          w_rd;

  // A push while full is only legal when the head leaves in the same cycle.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= din;
  end

  assign occ   = r_occ;
  assign full  = (r_occ == FULL_OCC);
  assign empty = (r_occ == '0);
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/pipe_result_sink.sv
// rtl/pipe_result_sink.sv - result FIFO, delivery counter, overflow flag
// Optional result checker enabled by PIPE_SINK_CHECK_EN.
module pipe_result_sink
  import pipe_sink_pkg::*;
#(
  parameter int N     = PIPE_N,
  parameter int DEPTH = 4,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             res_valid,
  input  logic [N-1:0]     res_data,
  output logic             out_valid,
  output logic [N-1:0]     out_data,
  input  logic             out_ready,
  output logic             full,
  output logic             ovf,
  output logic [CNT_W-1:0] rslt_cnt,
  input  logic             iss_valid,
  input  logic [N-1:0]     iss_a,
  input  logic [N-1:0]     iss_b,
  input  logic [N-1:0]     iss_c,
  input  logic [N-1:0]     iss_d,
  output logic             chk_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_unused_empty;
  logic [$clog2(DEPTH):0]  w_occ;
  logic                    r_ovf;
  logic [CNT_W-1:0]        r_rslt_cnt;

  assign w_pop  = out_valid & out_ready;
  assign w_push = res_valid & (~w_full | w_pop);

  pipe_sink_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .pop   (w_pop),
    .din   (res_data),
    .dout  (out_data),
    .occ   (w_occ),
    .full  (w_full),
    .empty (w_unused_empty)
  );

  assign out_valid = (w_occ != '0);
  assign full      = w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf      <= 1'b0;
      r_rslt_cnt <= '0;
    end else begin
      if (res_valid & w_full & ~w_pop) r_ovf <= 1'b1;
      if (w_pop) r_rslt_cnt <= r_rslt_cnt + 1'b1;
    end
  end

  assign ovf      = r_ovf;
  assign rslt_cnt = r_rslt_cnt;

`ifdef PIPE_SINK_CHECK_EN
  dly_entry_t       r_dly [LAT];
  dly_entry_t       w_dly_out;
  logic             w_err;
  logic             r_chk_err;
  logic [ERR_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) r_dly[i] <= '0;
    end else begin
      r_dly[0] <= '{vld: iss_valid, exp: pipe_expect(iss_a, iss_b, iss_c, iss_d)};
      for (int i = 1; i < LAT; i++) r_dly[i] <= r_dly[i-1];
    end
  end

  // Orphan and missing results both show up as a valid-bit disagreement.
  assign w_dly_out = r_dly[LAT-1];
  assign w_err     = (res_valid ^ w_dly_out.vld) |
                     (res_valid & w_dly_out.vld & (w_dly_out.exp != res_data));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_err) begin
      r_chk_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign chk_err = r_chk_err;
  assign err_cnt = r_err_cnt;
`else
  logic w_unused_iss;
  assign w_unused_iss = ^{iss_valid, iss_a, iss_b, iss_c, iss_d};
  assign chk_err      = 1'b0;
  assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_result_sink.sv
// tb/tb_pipe_result_sink.sv - directed self-checking bench for pipe_result_sink
module tb_pipe_result_sink;

  localparam int N     = 10;
  localparam int DEPTH = 4;
  localparam int LAT   = 3;

`ifdef PIPE_SINK_CHECK_EN
  localparam logic [31:0] E_ERR1 = 1;
  localparam logic [31:0] E_ERR2 = 2;
`else
  localparam logic [31:0] E_ERR1 = 0;
  localparam logic [31:0] E_ERR2 = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          res_valid = 1'b0;
  logic [N-1:0]  res_data = '0;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic          full;
  logic          ovf;
  logic [15:0]   rslt_cnt;
  logic          iss_valid = 1'b0;
  logic [N-1:0]  iss_a = '0;
  logic [N-1:0]  iss_b = '0;
  logic [N-1:0]  iss_c = '0;
  logic [N-1:0]  iss_d = '0;
  logic          chk_err;
  logic [7:0]    err_cnt;

  logic          pv [LAT];
  logic [N-1:0]  pd [LAT];
  int            n_tests = 0;
  int            n_fail  = 0;

  pipe_result_sink #(.N(N), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_data  (res_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .full      (full),
    .ovf       (ovf),
    .rslt_cnt  (rslt_cnt),
    .iss_valid (iss_valid),
    .iss_a     (iss_a),
    .iss_b     (iss_b),
    .iss_c     (iss_c),
    .iss_d     (iss_d),
    .chk_err   (chk_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; the upstream pipeline is emulated as a LAT-deep shift of issues.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = iss_valid;
    pd[0] = N'(((iss_a + iss_b) + (iss_c - iss_d)) * iss_d);
    res_valid = pv[LAT-1];
    res_data  = pd[LAT-1];
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] c, input logic [N-1:0] d);
    iss_a = a; iss_b = b; iss_c = c; iss_d = d;
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    #3;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_rslt_cnt", rslt_cnt, 0);
    check_eq("rst_chk_err", chk_err, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T2 single result
    out_ready = 1'b0;
    issue(10, 12, 6, 3);
    tick();
    tick();
    check_eq("t2_not_yet_valid", out_valid, 0);
    tick();
    check_eq("t2_out_valid", out_valid, 1);
    check_eq("t2_out_data", out_data, 75);
    out_ready = 1'b1;
    tick();
    check_eq("t2_rslt_cnt", rslt_cnt, 1);
    check_eq("t2_empty_after_pop", out_valid, 0);
    check_eq("t2_chk_err", chk_err, 0);

    // T3 back-to-back stream
    issue(20, 11, 1, 4);
    issue(8, 15, 5, 0);
    issue(30, 1, 2, 4);
    tick();
    check_eq("t3_v0", out_valid, 1);
    check_eq("t3_d0", out_data, 112);
    tick();
    check_eq("t3_v1", out_valid, 1);
    check_eq("t3_d1", out_data, 0);
    tick();
    check_eq("t3_v2", out_valid, 1);
    check_eq("t3_d2", out_data, 116);
    tick();
    check_eq("t3_drained", out_valid, 0);
    check_eq("t3_err_cnt", err_cnt, 0);
    check_eq("t3_rslt_cnt", rslt_cnt, 4);

    // T4 backpressure and overflow
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) issue(N'(k), 0, 1, 1);
    tick();
    tick();
    check_eq("t4_full", full, 1);
    check_eq("t4_no_ovf_yet", ovf, 0);
    check_eq("t4_head_stable", out_data, 1);
    tick();
    check_eq("t4_ovf", ovf, 1);
    check_eq("t4_still_full", full, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check_eq("t4_drain_data", out_data, k);
      tick();
    end
    check_eq("t4_drained", out_valid, 0);
    check_eq("t4_not_full", full, 0);
    check_eq("t4_rslt_cnt", rslt_cnt, 8);

    // T1 reset mid-stream
    out_ready = 1'b0;
    issue(2, 0, 1, 1);
    issue(3, 0, 1, 1);
    tick();
    tick();
    tick();
    check_eq("t1_buffered", out_valid, 1);
    check_eq("t1_head", out_data, 2);
    rst_n = 1'b0;
    #1;
    check_eq("t1_out_valid", out_valid, 0);
    check_eq("t1_rslt_cnt", rslt_cnt, 0);
    check_eq("t1_ovf", ovf, 0);
    check_eq("t1_out_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T5 push and pop together while full
    out_ready = 1'b0;
    for (int k = 6; k <= 10; k++) issue(N'(k), 0, 1, 1);
    tick();
    tick();
    check_eq("t5_full", full, 1);
    out_ready = 1'b1;
    tick();
    check_eq("t5_full_kept", full, 1);
    check_eq("t5_no_ovf", ovf, 0);
    check_eq("t5_rslt_cnt", rslt_cnt, 1);
    for (int k = 7; k <= 10; k++) begin
      check_eq("t5_drain_data", out_data, k);
      tick();
    end
    check_eq("t5_drained", out_valid, 0);
    check_eq("t5_rslt_cnt_end", rslt_cnt, 5);

    // T6 checker: corrupted result then orphan
    issue(10, 10, 5, 3);
    tick();
    tick();
    res_data = 65;
    tick();
    check_eq("t6_chk_err", chk_err, E_ERR1);
    check_eq("t6_err_cnt1", err_cnt, E_ERR1);
    res_valid = 1'b1;
    res_data  = 1;
    tick();
    check_eq("t6_err_cnt2", err_cnt, E_ERR2);
    check_eq("t6_chk_err_sticky", chk_err, E_ERR1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
